// File: rtl/sprite_rom_arbiter.sv
// Two-requester arbiter for the shared single-port sprite ROM (door + heart renderers).
// Define SPRITE_ARB_FIXED_PRIO_EN to give the door renderer absolute priority instead of round-robin.
`timescale 1ns/1ps

module sprite_rom_arbiter #(
  parameter int unsigned ADDR_W  = 15,
  parameter int unsigned DATA_W  = 24,
  parameter int unsigned ROM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  output logic              req1_ready,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              rsp0_valid,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp_data
);

  typedef enum logic {
    REQ_DOOR  = 1'b0,
    REQ_HEART = 1'b1
  } req_id_t;

  localparam int unsigned DEPTH = ROM_LAT + 1;

  req_id_t          last;
  logic             gnt0;
  logic             gnt1;
  logic [DEPTH-1:0] tag_vld;
  req_id_t          tag_id [DEPTH];

  // Grant is a function of the valids and last only, so it never loops back through ready.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset) begin
`ifdef SPRITE_ARB_FIXED_PRIO_EN
      gnt0 = req0_valid;
      gnt1 = req1_valid & ~req0_valid;
`else
      gnt0 = req0_valid & (~req1_valid | (last == REQ_HEART));
      gnt1 = req1_valid & (~req0_valid | (last == REQ_DOOR));
`endif
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last     <= REQ_HEART;
      rom_en   <= 1'b0;
      rom_addr <= '0;
      tag_vld  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        tag_id[i] <= REQ_DOOR;
      end
    end else begin
      rom_en <= gnt0 | gnt1;
      if (gnt0) begin
        rom_addr <= req0_addr;
        last     <= REQ_DOOR;
      end else if (gnt1) begin
        rom_addr <= req1_addr;
        last     <= REQ_HEART;
      end
      // Stage 0 lines up with rom_en; the last stage lines up with rom_data.
      tag_vld   <= {tag_vld[DEPTH-2:0], gnt0 | gnt1};
      tag_id[0] <= gnt1 ? REQ_HEART : REQ_DOOR;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        tag_id[i] <= tag_id[i-1];
      end
    end
  end

  assign rsp0_valid = tag_vld[DEPTH-1] & (tag_id[DEPTH-1] == REQ_DOOR);
  assign rsp1_valid = tag_vld[DEPTH-1] & (tag_id[DEPTH-1] == REQ_HEART);
  assign rsp_data   = rom_data;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Scoreboard bench for sprite_rom_arbiter: one instance at ROM_LAT=1 and one at ROM_LAT=3, same stimulus.
`timescale 1ns/1ps

module tb_sprite_rom_arbiter;
  localparam int AW = 15;
  localparam int DW = 24;
`ifdef SPRITE_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  typedef struct {
    int            id;
    logic [AW-1:0] addr;
    int            cyc;
  } exp_t;

  logic          clk   = 1'b0;
  logic          reset = 1'b0;
  logic          req0_valid = 1'b0;
  logic          req1_valid = 1'b0;
  logic [AW-1:0] req0_addr  = '0;
  logic [AW-1:0] req1_addr  = '0;

  logic          req0_ready [2];
  logic          req1_ready [2];
  logic          rom_en     [2];
  logic [AW-1:0] rom_addr   [2];
  logic [DW-1:0] rom_data   [2];
  logic          rsp0_valid [2];
  logic          rsp1_valid [2];
  logic [DW-1:0] rsp_data   [2];

  exp_t rq [2][$];
  exp_t sq [2][$];
  int   nvec = 0;
  int   nfail = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sprite_rom_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ROM_LAT(1)) u_dut_l1 (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_ready(req0_ready[0]),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_ready(req1_ready[0]),
    .rom_en(rom_en[0]), .rom_addr(rom_addr[0]), .rom_data(rom_data[0]),
    .rsp0_valid(rsp0_valid[0]), .rsp1_valid(rsp1_valid[0]), .rsp_data(rsp_data[0])
  );

  sprite_rom_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ROM_LAT(3)) u_dut_l3 (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_ready(req0_ready[1]),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_ready(req1_ready[1]),
    .rom_en(rom_en[1]), .rom_addr(rom_addr[1]), .rom_data(rom_data[1]),
    .rsp0_valid(rsp0_valid[1]), .rsp1_valid(rsp1_valid[1]), .rsp_data(rsp_data[1])
  );

  function automatic logic [DW-1:0] rom_fn(input logic [AW-1:0] a);
    if (a == 15'h0005) return 24'hFF0000;
    return {a[7:0], 1'b0, a};
  endfunction

  function automatic int lat(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  // Behavioural ROMs with latency 1 and 3
  logic [DW-1:0] pa0;
  logic [DW-1:0] pb0, pb1, pb2;
  always @(posedge clk) begin
    pa0 <= rom_en[0] ? rom_fn(rom_addr[0]) : '0;
    pb0 <= rom_en[1] ? rom_fn(rom_addr[1]) : '0;
    pb1 <= pb0;
    pb2 <= pb1;
  end
  assign rom_data[0] = pa0;
  assign rom_data[1] = pb2;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops expectations whenever a DUT shows a ROM strobe or a response
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        if (rom_en[i]) begin
          if (rq[i].size() == 0) begin
            nvec++; nfail++;
            $display("FAIL rom_en_unexpected dut%0d: got 1 expected 0 at cycle %0d", i, cyc);
          end else begin
            e = rq[i].pop_front();
            chk($sformatf("rom_addr dut%0d", i), 64'(rom_addr[i]), 64'(e.addr));
            chk($sformatf("rom_en_cycle dut%0d", i), 64'(cyc), 64'(e.cyc + 1));
          end
        end
        if (rsp0_valid[i] && rsp1_valid[i]) begin
          nvec++; nfail++;
          $display("FAIL rsp_both dut%0d: got rsp0=1 rsp1=1 expected one-hot at cycle %0d", i, cyc);
        end else if (rsp0_valid[i] || rsp1_valid[i]) begin
          if (sq[i].size() == 0) begin
            nvec++; nfail++;
            $display("FAIL rsp_unexpected dut%0d: got rsp1=%0d expected none at cycle %0d",
                     i, rsp1_valid[i], cyc);
          end else begin
            e = sq[i].pop_front();
            chk($sformatf("rsp_id dut%0d", i), 64'(rsp1_valid[i]), 64'(e.id));
            chk($sformatf("rsp_data dut%0d", i), 64'(rsp_data[i]), 64'(rom_fn(e.addr)));
            chk($sformatf("rsp_cycle dut%0d", i), 64'(cyc), 64'(e.cyc + 1 + lat(i)));
          end
        end
      end
    end
  end

  task automatic apply(input logic v0, input logic [AW-1:0] a0, input logic v1,
                       input logic [AW-1:0] a1, input logic eg0, input logic eg1);
    exp_t e;
    req0_valid = v0; req0_addr = a0;
    req1_valid = v1; req1_addr = a1;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("req0_ready dut%0d", i), 64'(req0_ready[i]), 64'(eg0));
      chk($sformatf("req1_ready dut%0d", i), 64'(req1_ready[i]), 64'(eg1));
      if (eg0 || eg1) begin
        e.id   = eg1 ? 1 : 0;
        e.addr = eg1 ? a1 : a0;
        e.cyc  = cyc;
        rq[i].push_back(e);
        sq[i].push_back(e);
      end
    end
  endtask

  task automatic step(input logic v0, input logic [AW-1:0] a0, input logic v1,
                      input logic [AW-1:0] a1, input logic eg0, input logic eg1);
    @(negedge clk);
    apply(v0, a0, v1, a1, eg0, eg1);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic flush();
    for (int i = 0; i < 2; i++) begin
      rq[i].delete();
      sq[i].delete();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    flush();
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic eg0;
    // Reset state: ready forced low even with both valids high
    reset = 1'b1;
    req0_valid = 1'b1; req0_addr = 15'h0010;
    req1_valid = 1'b1; req1_addr = 15'h4440;
    @(negedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_req0_ready dut%0d", i), 64'(req0_ready[i]), 64'd0);
      chk($sformatf("rst_req1_ready dut%0d", i), 64'(req1_ready[i]), 64'd0);
      chk($sformatf("rst_rom_en dut%0d", i), 64'(rom_en[i]), 64'd0);
      chk($sformatf("rst_rom_addr dut%0d", i), 64'(rom_addr[i]), 64'd0);
      chk($sformatf("rst_rsp0 dut%0d", i), 64'(rsp0_valid[i]), 64'd0);
      chk($sformatf("rst_rsp1 dut%0d", i), 64'(rsp1_valid[i]), 64'd0);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    // Single request, data 0xFF0000
    step(1'b1, 15'h0005, 1'b0, '0, 1'b1, 1'b0);
    idle(5);

    // Contention from reset: 0,1,0,1,0 (fixed prio: all 0), then req0 drops and req1 wins
    do_reset();
    for (int k = 0; k < 5; k++) begin
      eg0 = FIXED ? 1'b1 : ((k % 2) == 0);
      step(1'b1, 15'h0010, 1'b1, 15'h4440, eg0, ~eg0);
    end
    step(1'b0, '0, 1'b1, 15'h4440, 1'b0, 1'b1);
    idle(5);

    // Sole requester streaming 0x4440..0x4449
    for (int k = 0; k < 10; k++) begin
      step(1'b0, '0, 1'b1, AW'(15'h4440 + k), 1'b0, 1'b1);
    end
    idle(6);

    // Reset mid-flight: grant req0, reset right after the edge
    step(1'b1, 15'h0123, 1'b0, '0, 1'b1, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    flush();
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("midrst_rom_en dut%0d", i), 64'(rom_en[i]), 64'd0);
      chk($sformatf("midrst_rom_addr dut%0d", i), 64'(rom_addr[i]), 64'd0);
    end
    step(1'b1, 15'h0010, 1'b1, 15'h4440, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    apply(1'b1, 15'h0010, 1'b1, 15'h4440, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 15'h4440, 1'b0, 1'b1);
    idle(8);

    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rom_q_left dut%0d", i), 64'(rq[i].size()), 64'd0);
      chk($sformatf("rsp_q_left dut%0d", i), 64'(sq[i].size()), 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
